// File: rtl/dac_spi_driver_pkg.sv
// Shared types and constants for the DAC SPI driver: FSM state encoding,
// default DAC command nibble, frame width and counter width helpers.
package dac_spi_driver_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_GAP   = 2'd3
  } state_t;

  // Command nibble that precedes every sample on the wire.
  localparam logic [3:0] DEFAULT_CMD = 4'b0011;
  localparam int CMD_BITS = 4;

  // Total bits per SPI frame: command nibble plus the sample.
  function automatic int frame_bits(input int size);
    return CMD_BITS + size;
  endfunction

  // Number of bits needed to hold 'value' (at least 1).
  function automatic int clogb2(input int value);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if (value >= (1 << i)) w = i + 1;
    end
    return w;
  endfunction

  // Shortest sample period that lets a whole frame plus its gap and one idle
  // cycle fit between two ticks.
  function automatic int min_sample_period(input int size, input int clk_div);
    return 1 + (frame_bits(size) + 1) * 2 * clk_div + 1;
  endfunction

endpackage

// File: rtl/dac_spi_driver_rate_divider.sv
// Free-running sample-rate counter producing a one-cycle tick every
// SAMPLE_PERIOD clocks; the tick is high while the count equals
// SAMPLE_PERIOD-1.
module rate_divider
  import dac_spi_driver_pkg::*;
#(
  parameter int SAMPLE_PERIOD = 100
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int CNT_W = clogb2(SAMPLE_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SAMPLE_PERIOD - 1);

  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;
  logic             tick_reg;

  // Wrap the counter at SAMPLE_PERIOD-1.
  always_comb begin
    cnt_next = (cnt_reg == CNT_LAST) ? '0 : cnt_reg + CNT_W'(1);
  end

  // Register the tick so it lines up with the cycle whose count is the last one.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else begin
      cnt_reg  <= cnt_next;
      tick_reg <= (cnt_next == CNT_LAST);
    end
  end

  assign tick = tick_reg;

endmodule

// File: rtl/dac_spi_driver.sv
// Serialises one {CMD, sample} word per sample tick to an SPI DAC
// (mode 0: sclk idles low, DAC samples mosi on the rising edge), and
// requests the next sample from upstream with a one-cycle pulse.
module dac_spi_driver
  import dac_spi_driver_pkg::*;
#(
  parameter int         SIZE          = 12,
  parameter int         CLK_DIV       = 2,
  parameter int         SAMPLE_PERIOD = 100,
  parameter logic [3:0] CMD           = DEFAULT_CMD,
  parameter bit         CHECK_CFG     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [SIZE-1:0] data,
  output logic            next,
  output logic            sclk,
  output logic            mosi,
  output logic            cs_n,
  output logic            busy,
  output logic            overrun
);

  localparam int BITS       = frame_bits(SIZE);
  localparam int BIT_W      = clogb2(BITS - 1);
  localparam int DIV_W      = clogb2(2 * CLK_DIV - 1);
  localparam int MIN_PERIOD = min_sample_period(SIZE, CLK_DIV);

  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(BITS - 1);
  localparam logic [DIV_W-1:0] DIV_RISE = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(2 * CLK_DIV - 1);

  logic            tick;
  state_t          state_reg;
  logic [BITS-1:0] shift_reg;
  logic [BIT_W-1:0] bit_cnt_reg;
  logic [DIV_W-1:0] div_reg;
  logic            next_reg;
  logic            sclk_reg;
  logic            mosi_reg;
  logic            cs_n_reg;
  logic            busy_reg;
  logic            overrun_reg;

  rate_divider #(
    .SAMPLE_PERIOD(SAMPLE_PERIOD)
  ) u_rate (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  // Frame sequencer: every output is set one cycle ahead so it comes
  // straight from a flop. The shift register rotates so that each bit
  // change happens together with the sclk falling edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg   <= ST_IDLE;
      shift_reg   <= '0;
      bit_cnt_reg <= '0;
      div_reg     <= '0;
      next_reg    <= 1'b0;
      sclk_reg    <= 1'b0;
      mosi_reg    <= 1'b0;
      cs_n_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      overrun_reg <= 1'b0;
    end else begin
      next_reg <= 1'b0;
      // Any tick that does not find the sequencer idle is lost; remember it.
      if (tick && (state_reg != ST_IDLE)) overrun_reg <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (tick) begin
            state_reg   <= ST_LOAD;
            shift_reg   <= {CMD, data};
            mosi_reg    <= CMD[3];
            cs_n_reg    <= 1'b0;
            next_reg    <= 1'b1;
            sclk_reg    <= 1'b0;
            bit_cnt_reg <= BIT_LAST;
            div_reg     <= '0;
            busy_reg    <= 1'b1;
          end
        end
        ST_LOAD: begin
          state_reg <= ST_SHIFT;
          div_reg   <= '0;
        end
        ST_SHIFT: begin
          if (div_reg == DIV_LAST) begin
            div_reg  <= '0;
            sclk_reg <= 1'b0;
            if (bit_cnt_reg == '0) begin
              state_reg <= ST_GAP;
              cs_n_reg  <= 1'b1;
            end else begin
              bit_cnt_reg <= bit_cnt_reg - BIT_W'(1);
              shift_reg   <= {shift_reg[BITS-2:0], shift_reg[BITS-1]};
              mosi_reg    <= shift_reg[BITS-2];
            end
          end else begin
            div_reg <= div_reg + DIV_W'(1);
            if (div_reg == DIV_RISE) sclk_reg <= 1'b1;
          end
        end
        ST_GAP: begin
          if (div_reg == DIV_LAST) begin
            state_reg <= ST_IDLE;
            busy_reg  <= 1'b0;
            div_reg   <= '0;
          end else begin
            div_reg <= div_reg + DIV_W'(1);
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  // Flag configurations whose sample period cannot hold a full frame.
  generate
    if (CHECK_CFG) begin : g_cfg_check
      cfg_legal: assert property (@(posedge clk) disable iff (!rst)
                                  SAMPLE_PERIOD >= MIN_PERIOD)
        else $error("dac_spi_driver: SAMPLE_PERIOD %0d below minimum %0d",
                    SAMPLE_PERIOD, MIN_PERIOD);
    end
  endgenerate

  assign next    = next_reg;
  assign sclk    = sclk_reg;
  assign mosi    = mosi_reg;
  assign cs_n    = cs_n_reg;
  assign busy    = busy_reg;
  assign overrun = overrun_reg;

endmodule

// File: tb/tb_dac_spi_driver.sv
// Scoreboard bench for dac_spi_driver: four instances cover the nominal
// frame, a counting sample source, an over-fast sample period and
// CLK_DIV=1; instance 0 also takes a reset in the middle of a frame.
module tb_dac_spi_driver;

  logic clk = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic end_checks(input int inst, input int q_left, input logic ovr,
                            input logic ovr_exp, input logic idle_e);
    check($sformatf("i%0d_frames_left", inst), q_left, 32'd0);
    check($sformatf("i%0d_overrun", inst), 32'(ovr), 32'(ovr_exp));
    check($sformatf("i%0d_idle_framing", inst), 32'(idle_e), 32'd0);
  endtask

  for (genvar gi = 0; gi < 4; gi++) begin : g_inst
    localparam int CD           = (gi == 3) ? 1 : 2;
    localparam int SP           = (gi == 2) ? 60 : 100;
    localparam bit CHK          = (gi == 2) ? 1'b0 : 1'b1;
    localparam int EXP_LOW      = (gi == 3) ? 33 : 65;
    localparam int EXP_BIT_PER  = (gi == 3) ? 2 : 4;
    localparam int EXP_NEXT_PER = (gi == 2) ? 120 : 100;

    logic        rst_l;
    logic [11:0] data_l;
    logic        next_l, sclk_l, mosi_l, cs_n_l, busy_l, overrun_l;
    logic [15:0] exp_q[$];
    logic        idle_err;
    logic        done_l = 1'b0;

    dac_spi_driver #(
      .SIZE(12), .CLK_DIV(CD), .SAMPLE_PERIOD(SP), .CMD(4'b0011), .CHECK_CFG(CHK)
    ) u_dut (
      .clk(clk), .rst(rst_l), .data(data_l), .next(next_l), .sclk(sclk_l),
      .mosi(mosi_l), .cs_n(cs_n_l), .busy(busy_l), .overrun(overrun_l)
    );

    // Monitor: samples on the falling clk edge, rebuilds each frame and
    // compares it against the next expected word.
    initial begin : mon
      logic        prev_cs, prev_sclk, prev_mosi, prev_next;
      logic        in_frame, in_gap, frame_err;
      int          cyc, low_cnt, nbits, gap_cnt, last_rise, last_next;
      logic [15:0] word, exp_w;
      prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_next = 1'b0;
      in_frame = 1'b0; in_gap = 1'b0; frame_err = 1'b0; idle_err = 1'b0;
      cyc = 0; low_cnt = 0; nbits = 0; gap_cnt = 0; last_rise = -1; last_next = -1;
      word = '0;
      forever begin
        @(negedge clk);
        cyc++;
        if (!rst_l) begin
          in_frame = 1'b0; in_gap = 1'b0; last_next = -1;
          prev_cs = 1'b1; prev_sclk = 1'b0; prev_mosi = 1'b0; prev_next = 1'b0;
        end else begin
          if (prev_cs && !cs_n_l) begin
            in_frame = 1'b1; in_gap = 1'b0; low_cnt = 0; nbits = 0; word = '0;
            frame_err = !next_l; last_rise = -1;
          end else if (next_l) begin
            idle_err = 1'b1;
          end
          if (next_l) begin
            if (prev_next) idle_err = 1'b1;
            if (last_next >= 0)
              check($sformatf("i%0d_next_period", gi), cyc - last_next, EXP_NEXT_PER);
            last_next = cyc;
          end
          if (!cs_n_l) begin
            low_cnt++;
            if (sclk_l && !prev_sclk) begin
              if (mosi_l != prev_mosi) frame_err = 1'b1;
              if (last_rise >= 0 && (cyc - last_rise) != EXP_BIT_PER) frame_err = 1'b1;
              last_rise = cyc;
              word = {word[14:0], mosi_l};
              nbits++;
            end
          end else if (sclk_l) begin
            idle_err = 1'b1;
          end
          if (!prev_cs && cs_n_l && in_frame) begin
            in_frame = 1'b0; in_gap = 1'b1; gap_cnt = 0;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL i%0d_frame_unexpected actual=%0h required=none", gi, word);
            end else begin
              exp_w = exp_q.pop_front();
              check($sformatf("i%0d_word", gi), 32'(word), 32'(exp_w));
            end
            check($sformatf("i%0d_bits", gi), nbits, 32'd16);
            check($sformatf("i%0d_cs_low", gi), low_cnt, EXP_LOW);
            check($sformatf("i%0d_framing", gi), 32'(frame_err), 32'd0);
          end
          if (in_gap) begin
            if (busy_l) gap_cnt++;
            else begin
              check($sformatf("i%0d_gap", gi), gap_cnt, EXP_BIT_PER);
              in_gap = 1'b0;
            end
          end
          prev_cs = cs_n_l; prev_sclk = sclk_l; prev_mosi = mosi_l; prev_next = next_l;
        end
      end
    end

    if (gi == 0) begin : g_scn_reset
      // Held sample 12'hA5C; reset in bit 7 of the third frame.
      initial begin
        int lat;
        rst_l = 1'b1; data_l = 12'hA5C;
        #2 rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("i0_reset_state", 32'({cs_n_l, sclk_l, mosi_l, next_l, busy_l, overrun_l}), 32'h20);
        exp_q.push_back(16'h3A5C);
        exp_q.push_back(16'h3A5C);
        @(negedge clk) rst_l = 1'b1;
        repeat (334) @(posedge clk);
        #2 check("i0_midframe_cs", 32'(cs_n_l), 32'd0);
        rst_l = 1'b0;
        #1 check("i0_abort", 32'({cs_n_l, sclk_l, next_l, busy_l}), 32'h8);
        repeat (3) @(posedge clk);
        exp_q.push_back(16'h3A5C);
        @(negedge clk) rst_l = 1'b1;
        lat = 0;
        for (int k = 1; k <= 200; k++) begin
          @(posedge clk);
          #1;
          if (!cs_n_l) begin
            lat = k;
            break;
          end
        end
        check("i0_load_latency", lat, 32'd100);
        repeat (80) @(posedge clk);
        #1 end_checks(0, exp_q.size(), overrun_l, 1'b0, idle_err);
        rst_l = 1'b0;
        done_l = 1'b1;
      end
    end else if (gi == 1) begin : g_scn_count
      // Counting source advanced by each next pulse.
      initial begin
        rst_l = 1'b1; data_l = 12'd0;
        #2 rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("i1_reset_state", 32'({cs_n_l, sclk_l, mosi_l, next_l, busy_l, overrun_l}), 32'h20);
        fork
          forever begin
            @(posedge clk);
            if (next_l) begin
              #1 data_l = data_l + 12'd1;
            end
          end
        join_none
        exp_q.push_back(16'h3000);
        exp_q.push_back(16'h3001);
        exp_q.push_back(16'h3002);
        exp_q.push_back(16'h3003);
        @(negedge clk) rst_l = 1'b1;
        repeat (480) @(posedge clk);
        #2 check("i1_source_count", 32'(data_l), 32'd4);
        end_checks(1, exp_q.size(), overrun_l, 1'b0, idle_err);
        rst_l = 1'b0;
        done_l = 1'b1;
      end
    end else if (gi == 2) begin : g_scn_overrun
      // Period 60 is too short: every other tick lands mid-frame.
      initial begin
        rst_l = 1'b1; data_l = 12'hA5C;
        #2 rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("i2_reset_state", 32'({cs_n_l, sclk_l, mosi_l, next_l, busy_l, overrun_l}), 32'h20);
        exp_q.push_back(16'h3A5C);
        exp_q.push_back(16'h3A5C);
        exp_q.push_back(16'h3A5C);
        @(negedge clk) rst_l = 1'b1;
        repeat (110) @(posedge clk);
        #1 check("i2_overrun_before", 32'(overrun_l), 32'd0);
        repeat (15) @(posedge clk);
        #1 check("i2_overrun_after", 32'(overrun_l), 32'd1);
        repeat (275) @(posedge clk);
        #1 end_checks(2, exp_q.size(), overrun_l, 1'b1, idle_err);
        rst_l = 1'b0;
        done_l = 1'b1;
      end
    end else begin : g_scn_div1
      // Fastest serial clock.
      initial begin
        rst_l = 1'b1; data_l = 12'hA5C;
        #2 rst_l = 1'b0;
        repeat (3) @(posedge clk);
        #1 check("i3_reset_state", 32'({cs_n_l, sclk_l, mosi_l, next_l, busy_l, overrun_l}), 32'h20);
        exp_q.push_back(16'h3A5C);
        exp_q.push_back(16'h3A5C);
        exp_q.push_back(16'h3A5C);
        @(negedge clk) rst_l = 1'b1;
        repeat (380) @(posedge clk);
        #1 end_checks(3, exp_q.size(), overrun_l, 1'b0, idle_err);
        rst_l = 1'b0;
        done_l = 1'b1;
      end
    end
  end

  // Wait for every scenario, bounded, then report.
  initial begin
    for (int k = 0; k < 3000; k++) begin
      @(posedge clk);
      if (g_inst[0].done_l && g_inst[1].done_l && g_inst[2].done_l && g_inst[3].done_l) break;
    end
    #2 check("all_done", 32'({g_inst[0].done_l, g_inst[1].done_l, g_inst[2].done_l, g_inst[3].done_l}), 32'hF);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dac_spi_driver.md
DAC_SPI_DRIVER -- requirements
Module: dac_spi_driver

Interface
REQ-001 Parameter SIZE, default 12, sample width in bits; matches the upstream sample source.
REQ-002 Parameter CLK_DIV, default 2, sclk half-period in clk cycles; legal range 1 and above.
REQ-003 Parameter SAMPLE_PERIOD, default 100, clk cycles between frame starts.
REQ-004 Parameter CMD, default 4'b0011, 4-bit DAC command prefix sent ahead of each sample.
REQ-005 Port clk, input, 1, the only clock; every register is clocked on its rising edge.
REQ-006 Port rst, input, 1, reset; asynchronous assert, active-low.
REQ-007 Port data, input, SIZE, current sample from the upstream source.
REQ-008 Port next, output, 1, one-cycle request pulse telling the upstream source to advance to the next sample.
REQ-009 Port sclk, output, 1, serial clock to the DAC; idles low.
REQ-010 Port mosi, output, 1, serial data to the DAC; sent MSB first.
REQ-011 Port cs_n, output, 1, DAC chip select, active-low.
REQ-012 Port busy, output, 1, high whenever the FSM is not IDLE.
REQ-013 Port overrun, output, 1, sticky flag; set when a sample tick arrives while not IDLE.

Function
REQ-014 Tick counter runs 0..SAMPLE_PERIOD-1 and wraps; tick is high in the cycle where the count equals SAMPLE_PERIOD-1.
REQ-015 FSM states: IDLE, LOAD, SHIFT, GAP.
REQ-016 IDLE with tick -> LOAD in the next cycle; IDLE without tick -> stay in IDLE.
REQ-017 LOAD, one cycle long:
- shift register <= {CMD, data};
- next = 1;
- cs_n = 0;
- mosi = CMD[3];
- sclk = 0;
- bit counter = BITS-1, where BITS = 4+SIZE.
REQ-018 SHIFT: each bit takes 2*CLK_DIV cycles, CLK_DIV with sclk low then CLK_DIV with sclk high; mosi changes only on the sclk falling edge, and the DAC samples it on the rising edge.
REQ-019 After the high phase of bit 0 -> GAP; sclk = 0, cs_n = 1.
REQ-020 GAP holds cs_n high for 2*CLK_DIV cycles, then -> IDLE.
REQ-021 cs_n stays low for exactly 1 + BITS*2*CLK_DIV cycles per frame, counted from LOAD through the last high phase.
REQ-022 next is asserted only in LOAD, for exactly one cycle.
- The latched word is the sample for this frame.
- The pulse prefetches the following sample, so upstream has a full SAMPLE_PERIOD to settle.
REQ-023 The first frame after reset transmits whatever data presents at the first LOAD.
REQ-024 If tick occurs in LOAD, SHIFT or GAP, the tick is dropped and overrun is set to 1; overrun clears only on reset.
REQ-025 A tick that occurs in the same cycle the FSM enters IDLE from GAP is also dropped and flagged.
REQ-026 The legal configuration is SAMPLE_PERIOD >= 1 + (BITS+1)*2*CLK_DIV + 1; a simulation-time check reports violations.
REQ-027 The bit counter and divider counter are sized with clogb2 of their maximum value; no arithmetic truncation is permitted.

Reset
REQ-028 While rst is low, the block immediately enters:
- FSM = IDLE; tick counter = 0; divider = 0; shift register = 0;
- next = 0; sclk = 0; mosi = 0; cs_n = 1; busy = 0; overrun = 0.
REQ-029 Reset asserted mid-frame aborts the frame at once: cs_n goes high asynchronously and no partial frame resumes.
REQ-030 After rst deasserts, the first tick occurs SAMPLE_PERIOD cycles later.

Structure
REQ-031 Shared include file dac_spi_defs.v holds the FSM state encodings, the default CMD and the BITS calculation; the block includes clogb2.v for counter widths.
REQ-032 One sub-module, rate_divider, generates the tick, parameterised by SAMPLE_PERIOD, with ports clk, rst, tick.
REQ-033 All outputs are driven straight from registers.

Verification
REQ-034 Bench configuration is SIZE=12, CLK_DIV=2, SAMPLE_PERIOD=100, with data held at 12'hA5C.
- Expected frame: mosi bits 0011_1010_0101_1100 MSB first across 16 sclk rising edges.
- cs_n low for 65 cycles.
REQ-035 Drive the bench with a counting data source that advances on next.
- Expected: one next pulse per 100 cycles.
- Expected: consecutive frames carry successive values 0, 1, 2, ...
REQ-036 Configure SAMPLE_PERIOD=60, below the legal minimum, with the check suppressed.
- Expected: overrun = 1 after the second tick.
- Expected: no frame is corrupted; each frame still has 16 bits.
REQ-037 Pull rst low at bit 7 of a frame.
- Expected: cs_n = 1, sclk = 0, next = 0 immediately.
- Expected: the first new LOAD occurs 100 cycles after release.
REQ-038 Run with CLK_DIV=1.
- Expected: sclk period of 2 clk cycles.
- Expected: cs_n low for 33 cycles.
- Expected: GAP of 2 cycles.
REQ-039 Check frame framing on every frame.
- Expected: no sclk edge while cs_n is high.
- Expected: mosi stable from 1 cycle before to 1 cycle after each sclk rising edge.
